// File: rtl/risc_pkg.sv
// Shared constants and state encoding for the instruction unit, its memory and their benches.
package risc_pkg;

    localparam int IW         = 13;
    localparam int AW         = 5;
    localparam int IMEM_DEPTH = 32;

    localparam logic [IW-1:0] NOP = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } imem_state_t;

endpackage

// File: rtl/risc_imem_ram.sv
// Instruction storage: one synchronous write port, one registered read port, no reset.
module risc_imem_ram #(
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int IW    = 13
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [IW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [IW-1:0] rdata
);

    logic [IW-1:0] mem [DEPTH];
    logic [IW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/risc_imem.sv
// Instruction memory with a valid/ready program loader; fetches return NOP until a load completes.
module risc_imem #(
    parameter int              DEPTH = risc_pkg::IMEM_DEPTH,
    parameter int              AW    = risc_pkg::AW,
    parameter int              IW    = risc_pkg::IW,
    parameter logic [IW-1:0]   NOP   = risc_pkg::NOP
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_start,
    input  logic          wr_valid,
    input  logic [IW-1:0] wr_data,
    input  logic          wr_last,
    output logic          wr_ready,
    input  logic [AW-1:0] pc,
    output logic [IW-1:0] instruction,
    output logic          run,
    output logic [AW:0]   load_count,
    output logic          load_err
);

    import risc_pkg::*;

    localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);

    imem_state_t   state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW:0]   load_count_q, load_count_d;
    logic          load_err_q, load_err_d;
    logic          wr_ready_q, wr_ready_d;
    logic          run_q, run_d;
    logic          fetch_ok_q, fetch_ok_d;
    logic          wr_fire;
    logic [IW-1:0] ram_rdata;

    assign wr_fire = wr_ready_q && wr_valid;

    always_comb begin
        state_d      = state_q;
        wptr_d       = wptr_q;
        load_count_d = load_count_q;
        load_err_d   = load_err_q;
        // Masking decision travels alongside the RAM read so both land on the same edge.
        fetch_ok_d   = run_q && ({1'b0, pc} < load_count_q);

        case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d      = LOAD;
                    wptr_d       = '0;
                    load_count_d = '0;
                    load_err_d   = 1'b0;
                end
            end
            LOAD: begin
                if (wr_fire) begin
                    if (load_count_q != FULL_COUNT) begin
                        load_count_d = load_count_q + 1'b1;
                    end
                    if (wptr_q != LAST_ADDR) begin
                        wptr_d = wptr_q + 1'b1;
                    end
                    if (wr_last) begin
                        state_d = RUN;
                    end else if (wptr_q == LAST_ADDR) begin
                        state_d    = RUN;
                        load_err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (load_start) begin
                    state_d      = LOAD;
                    wptr_d       = '0;
                    load_count_d = '0;
                    load_err_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        wr_ready_d = (state_d == LOAD);
        run_d      = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wptr_q       <= '0;
            load_count_q <= '0;
            load_err_q   <= 1'b0;
            wr_ready_q   <= 1'b0;
            run_q        <= 1'b0;
            fetch_ok_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            load_count_q <= load_count_d;
            load_err_q   <= load_err_d;
            wr_ready_q   <= wr_ready_d;
            run_q        <= run_d;
            fetch_ok_q   <= fetch_ok_d;
        end
    end

    risc_imem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .IW    (IW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_fire),
        .waddr (wptr_q),
        .wdata (wr_data),
        .raddr (pc),
        .rdata (ram_rdata)
    );

    assign instruction = fetch_ok_q ? ram_rdata : NOP;
    assign wr_ready    = wr_ready_q;
    assign run         = run_q;
    assign load_count  = load_count_q;
    assign load_err    = load_err_q;

endmodule

// File: doc/risc_imem.md
# risc_imem

Instruction memory and program loader feeding `risc_iunit`. It is the responder side of the fetch interface: it takes the unit's `pc` and returns the addressed 13-bit instruction one cycle later. A host first loads a program through a valid/ready write port. Fetches return NOP until a complete load has been accepted.

## Interface
- `DEPTH`, 32: number of instruction words; must be ≤ 2^`AW`.
- `AW`, 5: address width; matches the `pc` width.
- `IW`, 13: instruction width; matches the `instruction`/`ir` width.
- `NOP`, 13'h0000: word returned whenever no valid instruction is available.

Ports (clock and reset first):
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `load_start`  in  1  one-cycle pulse; begins a program load.
- `wr_valid`  in  1  host write word valid.
- `wr_data`  in  IW  host write word.
- `wr_last`  in  1  qualifies the final word of the program.
- `wr_ready`  out  1  loader accepts a word this cycle.
- `pc`  in  AW  fetch address from the instruction unit.
- `instruction`  out  IW  registered fetch data to the instruction unit.
- `run`  out  1  a program is loaded and fetches are live.
- `load_count`  out  AW+1  number of words accepted in the current or last load.
- `load_err`  out  1  sticky: load was terminated by overflow, not by `wr_last`.

## Operation
- FSM states:
  - IDLE (after reset): go to LOAD on `load_start`.
  - LOAD: `wr_ready`=1.
    - A word transfers when `wr_valid && wr_ready`. It is written to `mem[wptr]`, then `wptr` and `load_count` increment.
    - A transfer with `wr_last`=1 moves the FSM to RUN.
    - A transfer into address DEPTH-1 with `wr_last`=0 also moves the FSM to RUN and sets `load_err`=1. This is the overflow case; the write still lands.
    - `load_start` is ignored in LOAD.
  - RUN: `run`=1. `load_start` returns the FSM to LOAD.
- Entering LOAD from any state clears `wptr`, `load_count` and `load_err` on the same edge, and `run` drops.
- Fetch rule: `instruction` is updated every cycle.
  - It equals `mem[pc]` if `run`=1 and `pc < load_count`.
  - Otherwise it equals NOP. This covers pc beyond the loaded program, pc ≥ DEPTH, and IDLE/LOAD.
- Memory contents are not reset. The fetch rule guarantees that uninitialised words are never visible.
- Arithmetic: `load_count` saturates at DEPTH. It is AW+1 bits wide so that DEPTH=32 is representable. `wptr` does not wrap, because overflow ends the load.

## Timing
- Reset values: `instruction`=NOP, `wr_ready`=0, `run`=0, `load_count`=0, `load_err`=0, state IDLE.
- Reset is asynchronous and may be asserted mid-load. The load is abandoned, the outputs take their reset values, and the next load starts at address 0.
- `wr_ready` rises in the cycle after the `load_start` pulse.
- `wr_ready` falls on the edge that accepts the final word. `run` rises on that same edge.
- Fetch latency is one cycle: `pc` sampled at edge n gives `instruction` valid after edge n.
- The first valid fetch is for `pc` sampled on the edge after `run` rises.
- Simultaneous `load_start` and a final write in LOAD: `load_start` is ignored, the write completes and the FSM enters RUN.
- Reading and writing the same cycle cannot occur, because fetch and load are in mutually exclusive states.

## Structure
- Shared package `risc_pkg`:
  - constants `IW`, `AW` and `NOP`.
  - state enum `imem_state_t` {IDLE, LOAD, RUN}.
  - These are shared with `risc_iunit` and its bench.
- Sub-module `risc_imem_ram`: DEPTH×IW storage with one synchronous write port and one synchronous read port, no reset. The `run`/`load_count` masking sits in the top level.

## Test plan
- Reset, no load → `instruction`=13'h0000 and `run`=0 for every `pc`.
- Load 13'h0208, 13'h05f1, 13'h06aa (`wr_last` on the third word), then drive pc=0,1,2,3 → `instruction`=13'h0208, 13'h05f1, 13'h06aa, 13'h0000, each one cycle after its pc; `load_count`=3, `load_err`=0.
- Toggle `wr_valid` on alternate cycles while loading 4 words → only the valid cycles are written; `run` rises on the edge of the 4th transfer.
- Load 32 words with no `wr_last` → RUN entered after word 31, `load_err`=1, `load_count`=32, pc=31 returns word 31.
- From RUN, pulse `load_start` and load 1 word 13'h1b04 → `load_err` clears, pc=0 returns 13'h1b04 and pc=1 returns 13'h0000.
- Assert `rst_n`=0 after 2 of 5 words → all outputs at reset values immediately; a reload starts at address 0.
